// File: rtl/video_pkg.sv
// Shared timing defaults, colour constants and pattern-select encoding for the
// video source stage.
package video_pkg;

  localparam int H_ACTIVE_1080 = 1920;
  localparam int H_FP_1080     = 88;
  localparam int H_SYNC_1080   = 44;
  localparam int H_BP_1080     = 148;
  localparam int V_ACTIVE_1080 = 1080;
  localparam int V_FP_1080     = 4;
  localparam int V_SYNC_1080   = 5;
  localparam int V_BP_1080     = 36;

  // Counter widths cover totals up to 4096 pixels x 2048 lines.
  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_tpg_pattern.sv
// Combinational test-pattern generator: maps a pixel position and pattern
// select onto an RGB colour. Blanking is applied by the caller.
module video_tpg_pattern
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_1080
) (
  input  logic [HCNT_W-1:0] x_i,
  input  logic [VCNT_W-1:0] y_i,
  input  logic [1:0]        pattern_i,
  input  logic [23:0]       solid_rgb_i,
  output logic [23:0]       rgb_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic       unused_y;

  // Threshold compare chain instead of a divide by the bar width.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_i) >= k * BAR_W) bar_idx = 3'(k);
    end
  end

  always_comb begin
    rgb_o = RGB_BLACK;
    case (pattern_e'(pattern_i))
      PAT_BARS:  rgb_o = bar_colour(bar_idx);
      PAT_RAMP:  rgb_o = {3{x_i[10:3]}};
      PAT_CHECK: rgb_o = (x_i[6] ^ y_i[6]) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID: rgb_o = solid_rgb_i;
    endcase
  end

  assign unused_y = ^{y_i[VCNT_W-1:7], y_i[5:0]};

endmodule

// File: rtl/video_timing_tpg.sv
// Raster timing generator with registered blank/sync/RGB outputs driving the
// downstream processing stage. Define TPG_MOTION_EN for horizontal scrolling.
module video_timing_tpg
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_1080,
  parameter int H_FP        = H_FP_1080,
  parameter int H_SYNC      = H_SYNC_1080,
  parameter int H_BP        = H_BP_1080,
  parameter int V_ACTIVE    = V_ACTIVE_1080,
  parameter int V_FP        = V_FP_1080,
  parameter int V_SYNC      = V_SYNC_1080,
  parameter int V_BP        = V_BP_1080,
  parameter int SCROLL_STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [23:0] vid_rgb_o,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);
  localparam logic [HCNT_W-1:0] HS_BEG  = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END  = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] VS_BEG  = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0] VS_END  = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [15:0]       frame_q, frame_d;
  logic [1:0]        pat_q, pat_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [1:0]        blank_q, blank_d;
  logic [2:0]        sync_q, sync_d;

  logic              h_wrap, v_wrap, at_origin;
  logic              hblank, vblank, hsync, vsync, de;
  logic [1:0]        pat_eff;
  logic [HCNT_W-1:0] x;
  logic [23:0]       pat_rgb;

  assign h_wrap    = (hcnt_q == H_LAST);
  assign v_wrap    = (vcnt_q == V_LAST);
  assign at_origin = (hcnt_q == '0) && (vcnt_q == '0);

  assign hblank = (hcnt_q >= HCNT_W'(H_ACTIVE));
  assign vblank = (vcnt_q >= VCNT_W'(V_ACTIVE));
  assign hsync  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
  assign vsync  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
  assign de     = ~hblank & ~vblank;

  // The first pixel of a frame already uses the select being latched there,
  // so a change applies to the whole following frame.
  assign pat_eff = at_origin ? pattern_sel_i : pat_q;

`ifdef TPG_MOTION_EN
  logic [11:0] scroll_q, scroll_d;
  logic [12:0] x_sum, scroll_sum;

  // Both sums stay below 2*H_ACTIVE while active, so one subtract is a modulo.
  always_comb begin
    x_sum      = {1'b0, hcnt_q} + {1'b0, scroll_q};
    x          = (x_sum >= 13'(H_ACTIVE)) ? 12'(x_sum - 13'(H_ACTIVE)) : x_sum[11:0];
    scroll_sum = {1'b0, scroll_q} + 13'(SCROLL_STEP);
    scroll_d   = scroll_q;
    if (cen_i && h_wrap && v_wrap) begin
      scroll_d = (scroll_sum >= 13'(H_ACTIVE)) ? 12'(scroll_sum - 13'(H_ACTIVE))
                                               : scroll_sum[11:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) scroll_q <= '0;
    else       scroll_q <= scroll_d;
  end
`else
  assign x = hcnt_q;
`endif

  video_tpg_pattern #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x_i         (x),
    .y_i         (vcnt_q),
    .pattern_i   (pat_eff),
    .solid_rgb_i (solid_rgb_i),
    .rgb_o       (pat_rgb)
  );

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    pat_d   = pat_q;
    rgb_d   = rgb_q;
    blank_d = blank_q;
    sync_d  = sync_q;
    if (cen_i) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        if (v_wrap) frame_d = frame_q + 16'd1;
      end
      if (at_origin) pat_d = pattern_sel_i;
      blank_d = {vblank, hblank};
      sync_d  = {de, vsync, hsync};
      rgb_d   = de ? pat_rgb : RGB_BLACK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      pat_q   <= '0;
      rgb_q   <= RGB_BLACK;
      blank_q <= 2'b11;
      sync_q  <= 3'b000;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      rgb_q   <= rgb_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign vid_rgb_o   = rgb_q;
  assign vh_blank_o  = blank_q;
  assign dvh_sync_o  = sync_q;
  assign frame_cnt_o = frame_q;

endmodule
